// File: rtl/waycache_ctrl_if.sv
// Controller-side bus of the way-halting I-cache:
// CPU handshake, tag-compare inputs, refill and tag-write strobes.
interface waycache_ctrl_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        flush;
  logic [3:0]  halt_match;
  logic [3:0]  main_match;
  logic        mem_valid;
  logic [3:0]  way_enable;
  logic        cpu_ready;
  logic [1:0]  hit_way;
  logic        cpu_stall;
  logic [31:0] lat_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        data_we;
  logic [2:0]  refill_word;
  logic        regWrite;
  logic [7:0]  set_dec;
  logic [3:0]  way_dec;

  modport slave (
    input  cpu_req, cpu_addr, flush,
    input  halt_match, main_match, mem_valid,
    output way_enable, cpu_ready, hit_way,
    output cpu_stall, lat_addr, mem_req,
    output mem_addr, data_we, refill_word,
    output regWrite, set_dec, way_dec
  );

  modport master (
    output cpu_req, cpu_addr, flush,
    output halt_match, main_match, mem_valid,
    input  way_enable, cpu_ready, hit_way,
    input  cpu_stall, lat_addr, mem_req,
    input  mem_addr, data_we, refill_word,
    input  regWrite, set_dec, way_dec
  );
endinterface

// File: rtl/waycache_ctrl.sv
// Sequencer for a 4-way, 8-set way-halting I-cache:
// valid/PLRU state, halt gating, refill and tag install.
module waycache_ctrl #(
  parameter int SETS  = 8,
  parameter int WAYS  = 4,
  parameter int BEATS = 8
) (
  input logic           clk,
  input logic           reset,
  waycache_ctrl_if.slave bus
);

  localparam int IW = $clog2(SETS);
  localparam int BW = $clog2(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [IW-1:0] LAST_SET  = IW'(SETS - 1);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, REFILL, UPDATE, FLUSH
  } state_t;

  state_t                      state_q, state_d;
  logic [SETS-1:0][WAYS-1:0]   valid_q, valid_d;
  logic [SETS-1:0][2:0]        plru_q, plru_d;
  logic [BW-1:0]               beat_q, beat_d;
  logic [IW-1:0]               fcnt_q, fcnt_d;
  logic [31:0]                 lat_q, lat_d;
  logic [1:0]                  vic_q, vic_d;

  logic [IW-1:0]   idx;
  logic [WAYS-1:0] way_en;
  logic [WAYS-1:0] hit_vec;
  logic            hit;
  logic [1:0]      hit_enc;
  logic [WAYS-1:0] inv;
  logic [1:0]      victim;

  logic            ready;
  logic            stall;
  logic            mreq;
  logic            dwe;
  logic [2:0]      rword;
  logic            rwr;
  logic [7:0]      sdec;
  logic [3:0]      wdec;

  function automatic logic [2:0] plru_upd(
    input logic [2:0] p,
    input logic [1:0] w
  );
    logic [2:0] r;
    r = p;
    if (!w[1]) begin
      r[0] = 1'b1;
      r[1] = (w == 2'd0);
    end else begin
      r[0] = 1'b0;
      r[2] = (w == 2'd2);
    end
    return r;
  endfunction

  assign idx     = lat_q[5 +: IW];
  assign way_en  = (state_q == LOOKUP)
                 ? (valid_q[idx] & bus.halt_match)
                 : '0;
  assign hit_vec = way_en & bus.main_match;
  assign hit     = |hit_vec;

  // Lowest matching way wins if several claim a hit
  always_comb begin
    hit_enc = 2'd0;
    priority case (1'b1)
      hit_vec[0]: hit_enc = 2'd0;
      hit_vec[1]: hit_enc = 2'd1;
      hit_vec[2]: hit_enc = 2'd2;
      hit_vec[3]: hit_enc = 2'd3;
      default:    hit_enc = 2'd0;
    endcase
  end

  // Victim: first free way, else follow the PLRU tree
  always_comb begin
    inv    = ~valid_q[idx];
    victim = 2'd0;
    priority case (1'b1)
      inv[0]: victim = 2'd0;
      inv[1]: victim = 2'd1;
      inv[2]: victim = 2'd2;
      inv[3]: victim = 2'd3;
      default:
        victim = plru_q[idx][0]
               ? {1'b1, plru_q[idx][2]}
               : {1'b0, plru_q[idx][1]};
    endcase
  end

  // Next-state and strobe logic
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    plru_d  = plru_q;
    beat_d  = beat_q;
    fcnt_d  = fcnt_q;
    lat_d   = lat_q;
    vic_d   = vic_q;
    ready   = 1'b0;
    stall   = 1'b1;
    mreq    = 1'b0;
    dwe     = 1'b0;
    rword   = 3'd0;
    rwr     = 1'b0;
    sdec    = 8'd0;
    wdec    = 4'd0;
    unique case (state_q)
      IDLE: begin
        stall = 1'b0;
        if (bus.flush) begin
          fcnt_d  = '0;
          state_d = FLUSH;
        end else if (bus.cpu_req) begin
          lat_d   = bus.cpu_addr;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          stall       = 1'b0;
          ready       = 1'b1;
          plru_d[idx] = plru_upd(plru_q[idx], hit_enc);
          state_d     = IDLE;
        end else begin
          vic_d   = victim;
          beat_d  = '0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        mreq = 1'b1;
        if (bus.mem_valid) begin
          dwe    = 1'b1;
          rword  = 3'(beat_q);
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT)
            state_d = UPDATE;
        end
      end
      UPDATE: begin
        rwr                 = 1'b1;
        sdec[idx]           = 1'b1;
        wdec[vic_q]         = 1'b1;
        valid_d[idx][vic_q] = 1'b1;
        plru_d[idx]         = plru_upd(plru_q[idx], vic_q);
        state_d             = LOOKUP;
      end
      FLUSH: begin
        valid_d[fcnt_q] = '0;
        plru_d[fcnt_q]  = '0;
        fcnt_d          = fcnt_q + 1'b1;
        if (fcnt_q == LAST_SET)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      plru_q  <= '0;
      beat_q  <= '0;
      fcnt_q  <= '0;
      lat_q   <= '0;
      vic_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      plru_q  <= plru_d;
      beat_q  <= beat_d;
      fcnt_q  <= fcnt_d;
      lat_q   <= lat_d;
      vic_q   <= vic_d;
    end
  end

  assign bus.way_enable  = way_en;
  assign bus.cpu_ready   = ready;
  assign bus.hit_way     = ready ? hit_enc : 2'd0;
  assign bus.cpu_stall   = stall;
  assign bus.lat_addr    = lat_q;
  assign bus.mem_req     = mreq;
  assign bus.mem_addr    = {lat_q[31:5], 5'b0};
  assign bus.data_we     = dwe;
  assign bus.refill_word = rword;
  assign bus.regWrite    = rwr;
  assign bus.set_dec     = sdec;
  assign bus.way_dec     = wdec;

endmodule

// File: tb/tb_waycache_ctrl.sv
// Self-checking bench for waycache_ctrl: tag-array model
// drives the match inputs, a cache model predicts results.
module tb_waycache_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  waycache_ctrl_if bus ();

  waycache_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Tag arrays written by the DUT's strobes
  logic [3:0]  env_halt [8][4];
  logic [19:0] env_main [8][4];
  bit          env_clr;
  bit          force_en;
  logic [3:0]  halt_f, main_f;
  logic [3:0]  hm, mm;

  always @(posedge clk) begin
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 4; w++)
        if (env_clr) begin
          env_halt[s][w] <= '0;
          env_main[s][w] <= '0;
        end else if (bus.regWrite && bus.set_dec[s]
                     && bus.way_dec[w]) begin
          env_halt[s][w] <= bus.lat_addr[11:8];
          env_main[s][w] <= bus.lat_addr[31:12];
        end
  end

  always_comb begin
    hm = '0;
    mm = '0;
    for (int w = 0; w < 4; w++) begin
      hm[w] = env_halt[bus.lat_addr[7:5]][w]
              == bus.lat_addr[11:8];
      mm[w] = env_main[bus.lat_addr[7:5]][w]
              == bus.lat_addr[31:12];
    end
    bus.halt_match = force_en ? halt_f : hm;
    bus.main_match = force_en ? main_f : mm;
  end

  // Behavioural cache model
  bit          m_valid [8][4];
  bit          m_b0 [8];
  bit          m_b1 [8];
  bit          m_b2 [8];
  logic [23:0] m_tag [8][4];

  function automatic void m_clear();
    for (int s = 0; s < 8; s++) begin
      m_b0[s] = 0; m_b1[s] = 0; m_b2[s] = 0;
      for (int w = 0; w < 4; w++) m_valid[s][w] = 0;
    end
  endfunction

  function automatic void m_lookup(
    input logic [31:0] a, output bit h, output int w);
    int s;
    s = int'(a[7:5]);
    h = 0;
    w = 0;
    for (int i = 3; i >= 0; i--)
      if (m_valid[s][i] && m_tag[s][i] == a[31:8]) begin
        h = 1;
        w = i;
      end
  endfunction

  function automatic int m_victim(input int s);
    for (int i = 0; i < 4; i++)
      if (!m_valid[s][i]) return i;
    if (m_b0[s]) return 2 + int'(m_b2[s]);
    return int'(m_b1[s]);
  endfunction

  function automatic void m_touch(input int s, input int w);
    if (w < 2) begin
      m_b0[s] = 1;
      m_b1[s] = (w == 0);
    end else begin
      m_b0[s] = 0;
      m_b2[s] = (w == 2);
    end
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1;
    bus.cpu_req = 0;
    bus.flush = 0;
    bus.mem_valid = 0;
    @(negedge clk);
    reset = 0;
    m_clear();
  endtask

  // One complete read, checked against the model
  task automatic read_txn(
    input  logic [31:0] addr,
    input  int          gap,
    output bit          was_hit,
    output int          way,
    output int          lat);
    int s, beats, cyc;
    bit eh;
    int ew;
    s = int'(addr[7:5]);
    m_lookup(addr, eh, ew);
    was_hit = eh;
    lat = 1;
    @(negedge clk);
    bus.cpu_req = 1;
    bus.cpu_addr = addr;
    n_cmp++;
    if (bus.cpu_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_stall: got %b want 0",
               bus.cpu_stall);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.cpu_ready !== eh) begin
      n_bad++;
      $display("FAIL lookup_ready a=%h: got %b want %b",
               addr, bus.cpu_ready, eh);
    end
    if (eh) begin
      n_cmp++;
      if (bus.hit_way !== 2'(ew)) begin
        n_bad++;
        $display("FAIL hit_way a=%h: got %0d want %0d",
                 addr, bus.hit_way, ew);
      end
      m_touch(s, ew);
      way = ew;
      bus.cpu_req = 0;
      return;
    end
    ew = m_victim(s);
    way = ew;
    n_cmp++;
    if (bus.cpu_stall !== 1'b1) begin
      n_bad++;
      $display("FAIL miss_stall: got %b want 1",
               bus.cpu_stall);
    end
    bus.cpu_addr = $urandom;
    beats = 0;
    cyc = 0;
    while (beats < 8 && cyc < 300) begin
      @(negedge clk);
      bus.mem_valid = ($urandom_range(0, gap) == 0);
      #1;
      cyc++;
      lat++;
      n_cmp++;
      if (bus.mem_req !== 1'b1
          || bus.mem_addr !== {addr[31:5], 5'b0}
          || bus.data_we !== bus.mem_valid
          || (bus.mem_valid
              && bus.refill_word !== beats[2:0])) begin
        n_bad++;
        $display("FAIL refill beat=%0d: req=%b addr=%h we=%b wd=%0d want req=1 addr=%h we=%b wd=%0d",
                 beats, bus.mem_req, bus.mem_addr,
                 bus.data_we, bus.refill_word,
                 {addr[31:5], 5'b0}, bus.mem_valid, beats);
      end
      if (bus.mem_valid) beats++;
    end
    if (beats < 8) begin
      n_bad++;
      $display("FAIL refill_timeout: got %0d beats want 8",
               beats);
      bus.cpu_req = 0;
      apply_reset();
      return;
    end
    @(negedge clk);
    bus.mem_valid = 0;
    lat++;
    n_cmp++;
    if (bus.regWrite !== 1'b1
        || bus.set_dec !== 8'(1 << s)
        || bus.way_dec !== 4'(1 << ew)) begin
      n_bad++;
      $display("FAIL update: rw=%b set=%b way=%b want rw=1 set=%b way=%b",
               bus.regWrite, bus.set_dec, bus.way_dec,
               8'(1 << s), 4'(1 << ew));
    end
    m_valid[s][ew] = 1;
    m_tag[s][ew] = addr[31:8];
    m_touch(s, ew);
    @(negedge clk);
    lat++;
    n_cmp++;
    if (bus.cpu_ready !== 1'b1 || bus.hit_way !== 2'(ew)) begin
      n_bad++;
      $display("FAIL replay: ready=%b way=%0d want ready=1 way=%0d",
               bus.cpu_ready, bus.hit_way, ew);
    end
    m_touch(s, ew);
    bus.cpu_req = 0;
  endtask

  task automatic do_flush(input bit with_req,
                          input logic [31:0] addr);
    int rdy;
    rdy = 0;
    @(negedge clk);
    bus.flush = 1;
    bus.cpu_req = with_req;
    bus.cpu_addr = addr;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.flush = 0;
      bus.cpu_req = 0;
      n_cmp++;
      if (bus.cpu_stall !== 1'b1 || bus.cpu_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL flush_cyc%0d: stall=%b ready=%b want 1/0",
                 k, bus.cpu_stall, bus.cpu_ready);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.cpu_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_end: stall=%b want 0",
               bus.cpu_stall);
    end
    m_clear();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1;
    env_clr = 1;
    @(negedge clk);
    n_cmp++;
    if (bus.cpu_stall !== 0 || bus.mem_req !== 0
        || bus.cpu_ready !== 0 || bus.data_we !== 0
        || bus.regWrite !== 0) begin
      n_bad++;
      $display("FAIL reset_ctl: stall=%b mreq=%b rdy=%b we=%b rw=%b want all 0",
               bus.cpu_stall, bus.mem_req, bus.cpu_ready,
               bus.data_we, bus.regWrite);
    end
    n_cmp++;
    if (bus.lat_addr !== 32'd0 || bus.mem_addr !== 32'd0
        || bus.set_dec !== 8'd0 || bus.way_dec !== 4'd0
        || bus.way_enable !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_bus: lat=%h maddr=%h set=%b way=%b en=%b want all 0",
               bus.lat_addr, bus.mem_addr, bus.set_dec,
               bus.way_dec, bus.way_enable);
    end
    reset = 0;
    env_clr = 0;
    m_clear();
  endtask

  task automatic test_cold_miss();
    bit h; int w, l;
    read_txn(32'h0000_1234, 0, h, w, l);
    n_cmp++;
    if (h !== 0 || w != 0 || l != 11) begin
      n_bad++;
      $display("FAIL cold_miss: hit=%b way=%0d lat=%0d want 0/0/11",
               h, w, l);
    end
    read_txn(32'h0000_1230, 2, h, w, l);
    n_cmp++;
    if (h !== 1 || w != 0) begin
      n_bad++;
      $display("FAIL cold_rehit: hit=%b way=%0d want 1/0", h, w);
    end
  endtask

  task automatic test_halt_gating();
    bit h; int w, l;
    logic [3:0] exp_en;
    apply_reset();
    read_txn(32'h0000_A120, 1, h, w, l);
    read_txn(32'h0000_B120, 1, h, w, l);
    force_en = 1;
    halt_f = 4'b0011;
    main_f = 4'b1110;
    exp_en = 4'b0;
    for (int i = 0; i < 4; i++)
      exp_en[i] = m_valid[1][i] & halt_f[i];
    @(negedge clk);
    bus.cpu_req = 1;
    bus.cpu_addr = 32'h0000_C120;
    @(negedge clk);
    n_cmp++;
    if (bus.way_enable !== exp_en || exp_en !== 4'b0011) begin
      n_bad++;
      $display("FAIL halt_en: got %b want %b",
               bus.way_enable, exp_en);
    end
    n_cmp++;
    if (bus.cpu_ready !== 1'b1 || bus.hit_way !== 2'd1) begin
      n_bad++;
      $display("FAIL halt_hit: ready=%b way=%0d want 1/1",
               bus.cpu_ready, bus.hit_way);
    end
    m_touch(1, 1);
    bus.cpu_req = 0;
    force_en = 0;
  endtask

  task automatic test_replacement();
    bit h; int w, l;
    apply_reset();
    read_txn(32'h0000_1140, 1, h, w, l);
    read_txn(32'h0000_2240, 1, h, w, l);
    read_txn(32'h0000_3340, 1, h, w, l);
    read_txn(32'h0000_4440, 1, h, w, l);
    read_txn(32'h0000_1140, 1, h, w, l);
    n_cmp++;
    if (h !== 1 || w != 0) begin
      n_bad++;
      $display("FAIL repl_hit0: hit=%b way=%0d want 1/0", h, w);
    end
    read_txn(32'h0000_5540, 1, h, w, l);
    n_cmp++;
    if (h !== 0 || w != 2) begin
      n_bad++;
      $display("FAIL repl_vic2: hit=%b way=%0d want 0/2", h, w);
    end
    read_txn(32'h0000_6640, 1, h, w, l);
    n_cmp++;
    if (h !== 0 || w != 1) begin
      n_bad++;
      $display("FAIL repl_vic1: hit=%b way=%0d want 0/1", h, w);
    end
  endtask

  task automatic test_reset_mid_refill();
    bit h; int w, l;
    apply_reset();
    read_txn(32'h0000_9060, 1, h, w, l);
    @(negedge clk);
    bus.cpu_req = 1;
    bus.cpu_addr = 32'h0000_7060;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.mem_valid = 1;
      #1;
      n_cmp++;
      if (bus.data_we !== 1'b1 || bus.refill_word !== 3'(i)) begin
        n_bad++;
        $display("FAIL midref_beat%0d: we=%b wd=%0d want 1/%0d",
                 i, bus.data_we, bus.refill_word, i);
      end
    end
    @(negedge clk);
    reset = 1;
    bus.mem_valid = 0;
    bus.cpu_req = 0;
    @(negedge clk);
    n_cmp++;
    if (bus.mem_req !== 1'b0 || bus.cpu_stall !== 1'b0
        || bus.lat_addr !== 32'd0) begin
      n_bad++;
      $display("FAIL midref_abort: mreq=%b stall=%b lat=%h want 0/0/0",
               bus.mem_req, bus.cpu_stall, bus.lat_addr);
    end
    reset = 0;
    m_clear();
    read_txn(32'h0000_7060, 1, h, w, l);
    n_cmp++;
    if (h !== 0 || w != 0) begin
      n_bad++;
      $display("FAIL midref_again: hit=%b way=%0d want 0/0", h, w);
    end
  endtask

  task automatic test_flush();
    bit h; int w, l;
    read_txn(32'h0000_8080, 1, h, w, l);
    read_txn(32'h0000_8080, 1, h, w, l);
    n_cmp++;
    if (h !== 1) begin
      n_bad++;
      $display("FAIL flush_pre: hit=%b want 1", h);
    end
    do_flush(1, 32'h0000_8080);
    read_txn(32'h0000_8080, 1, h, w, l);
    n_cmp++;
    if (h !== 0) begin
      n_bad++;
      $display("FAIL flush_post: hit=%b want 0", h);
    end
  endtask

  task automatic test_back_to_back();
    bit h; int w, l;
    logic [31:0] a [3];
    a[0] = 32'h0001_2300;
    a[1] = 32'h0004_56A0;
    a[2] = 32'h0007_89E4;
    for (int i = 0; i < 3; i++) read_txn(a[i], 1, h, w, l);
    @(negedge clk);
    bus.cpu_req = 1;
    bus.cpu_addr = a[0];
    bus.mem_valid = 1;
    for (int i = 0; i < 3; i++) begin
      m_lookup(a[i], h, w);
      @(negedge clk);
      n_cmp++;
      if (bus.cpu_ready !== 1'b1 || bus.hit_way !== 2'(w)
          || bus.data_we !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_hit%0d: rdy=%b way=%0d we=%b want 1/%0d/0",
                 i, bus.cpu_ready, bus.hit_way, bus.data_we, w);
      end
      m_touch(int'(a[i][7:5]), w);
      if (i < 2) bus.cpu_addr = a[i+1];
      else bus.cpu_req = 0;
      @(negedge clk);
      n_cmp++;
      if (bus.cpu_ready !== 1'b0 || bus.data_we !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_gap%0d: rdy=%b we=%b want 0/0",
                 i, bus.cpu_ready, bus.data_we);
      end
    end
    bus.mem_valid = 0;
  endtask

  task automatic test_random();
    bit h; int w, l;
    logic [31:0] a;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 14) == 0) begin
        do_flush($urandom_range(0, 1) == 1, $urandom);
      end else begin
        a = {12'h0, 4'($urandom_range(0, 3)),
             4'($urandom_range(0, 2)), 3'($urandom_range(0, 7)),
             3'($urandom), 2'b00};
        a[31:28] = 4'($urandom_range(0, 1));
        read_txn(a, 3, h, w, l);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    env_clr = 1;
    force_en = 0;
    halt_f = '0;
    main_f = '0;
    bus.cpu_req = 0;
    bus.cpu_addr = '0;
    bus.flush = 0;
    bus.mem_valid = 0;
    test_reset();
    test_cold_miss();
    test_halt_gating();
    test_replacement();
    test_reset_mid_refill();
    test_flush();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/waycache_ctrl.md
Name: waycache_ctrl

Overview:
- Sequencing controller for a 4-way, 8-set way-halting cache built from halt-tag arrays (4 bit) and main-tag arrays (20 bit) of enable-gated flip-flops.
- Holds the valid bits and pseudo-LRU state, and gates main-tag/data compare using halt-tag matches.
- Runs the miss refill handshake with memory, then drives the tag-array write strobes (regWrite, set/way decode) to install the new tag.
- Read-only cache (instruction side), with a set-stepping flush.

Parameters:
- SETS, 8, number of sets; index width 3. Only the default is supported.
- WAYS, 4, associativity. Only the default is supported.
- BEATS, 8, words per block, equal to refill beats; counter width 3.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  read request; sampled only in IDLE
- cpu_addr  in  32  byte address. Fields: [31:12] main tag, [11:8] halt tag, [7:5] index, [4:2] word, [1:0] byte.
- flush  in  1  invalidate all lines; sampled only in IDLE
- halt_match  in  4  per-way compare of the stored halt tag (indexed set) against lat_addr[11:8]
- main_match  in  4  per-way compare of the stored main tag (indexed set) against lat_addr[31:12]
- mem_valid  in  1  one refill beat present this cycle
- way_enable  out  4  valid[idx] & halt_match in LOOKUP, else 0; gates main-tag/data read
- cpu_ready  out  1  hit response pulse
- hit_way  out  2  way that hit; meaningful only with cpu_ready
- cpu_stall  out  1  controller busy
- lat_addr  out  32  latched request address; drives array index and compare inputs
- mem_req  out  1  refill request
- mem_addr  out  32  {lat_addr[31:5], 5'b0}
- data_we  out  1  write the current refill beat into the data array
- refill_word  out  3  beat index for data_we
- regWrite  out  1  tag-array write strobe
- set_dec  out  8  one-hot set select (decOut1b per set)
- way_dec  out  4  one-hot victim way select

Behaviour:
- Reset values:
  - state = IDLE.
  - All 32 valid bits = 0; all PLRU bits = 000; beat and flush counters = 0; lat_addr = 0.
  - All outputs 0.
  - Reset in any state, including mid-refill or mid-flush, aborts immediately; mem_req drops in the next cycle.
- States: IDLE, LOOKUP, REFILL, UPDATE, FLUSH.
- IDLE:
  - flush=1 goes to FLUSH; flush has priority over cpu_req.
  - Otherwise cpu_req=1 latches cpu_addr into lat_addr and goes to LOOKUP.
  - cpu_stall = 0.
- LOOKUP (one cycle):
  - hit = |(way_enable & main_match).
  - On hit: cpu_ready=1 and hit_way = encoded way. If more than one way matches (illegal), the lowest way wins. Update PLRU; go to IDLE.
  - On miss: choose victim, reset beat counter, go to REFILL.
  - Hit latency: request accepted in cycle n, cpu_ready in cycle n+1.
- Victim selection:
  - Lowest-numbered invalid way in the set, if any.
  - Otherwise PLRU: b0=0 selects way b1 (0 or 1); b0=1 selects way 2+b2.
- PLRU update on access to way w:
  - w in {0,1}: b0=1, b1=(w==0).
  - w in {2,3}: b0=0, b2=(w==2).
  - Applied on hit and in UPDATE.
- REFILL:
  - mem_req=1 every cycle.
  - Each mem_valid=1 cycle: data_we=1 and refill_word=counter, then counter increments.
  - mem_valid on the beat where counter==7 goes to UPDATE.
  - mem_valid outside REFILL is ignored.
- UPDATE (one cycle):
  - regWrite=1, set_dec = onehot(lat_addr[7:5]), way_dec = onehot(victim).
  - Tag arrays capture lat_addr[31:8] this edge. Set valid[idx][victim]=1; update PLRU with the victim.
  - Go to LOOKUP to replay; the replay must hit.
- FLUSH:
  - 8 cycles; cycle k clears valid[k][3:0] and PLRU[k]; after k=7 go to IDLE.
  - Tag contents are untouched.
- cpu_stall = 1 in every state except IDLE, and except LOOKUP when hit.
- Request handshake:
  - CPU holds cpu_req/cpu_addr until cpu_ready.
  - Changes to cpu_addr after acceptance have no effect.
  - cpu_req still high in the cycle after cpu_ready is a new request.
- regWrite, data_we, cpu_ready and set_dec/way_dec are 0 in all states other than those named above.

Test Plan:
- Cold miss: reset, then read 0x0000_1234 -> LOOKUP miss; mem_req with mem_addr=0x0000_1220; 8 mem_valid beats -> data_we x8 with refill_word 0..7. UPDATE: regWrite=1, set_dec=8'b0000_0010, way_dec=0001. Replay hit, cpu_ready=1, hit_way=0; miss-to-ready = beats+3 cycles.
- Halt gating: valid ways 0,1 in set 1, halt_match=0011, main_match=1110 -> way_enable=0011, hit on way 1, cpu_ready one cycle after acceptance.
- Replacement: fill ways 0..3 of set 2 with distinct tags, hit way 0, then miss -> victim way 2 (PLRU b0=1, b2=0); next forced miss -> victim way 1.
- Reset mid-refill: reset after 3 beats -> mem_req=0 next cycle, state IDLE, same read misses again with victim way 0.
- Flush vs request: flush=1 and cpu_req=1 together in IDLE -> 8 stall cycles, no cpu_ready; a following read of a previously cached address misses.
- Back-to-back hits with cpu_req held high -> cpu_ready every other cycle; mem_valid pulses during hits cause no data_we.
